// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU command sequencer: function codes, the
// load-immediate opcode bit, FSM states and flag-register bit positions.
package alu4_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_XOR = 3'b100;
  localparam logic [2:0] FN_NOT = 3'b101;
  localparam logic [2:0] FN_LT  = 3'b110;
  localparam logic [2:0] FN_EQ  = 3'b111;

  localparam int OP_LI_BIT = 3;

  localparam int FLG_Z = 0;
  localparam int FLG_O = 1;
  localparam int FLG_C = 2;
  localparam int FLG_S = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Subtract and both compares run the ALU adder as a + ~b + 1.
  function automatic logic fn_uses_cin(input logic [2:0] fn);
    return (fn == FN_SUB) || (fn == FN_LT) || (fn == FN_EQ);
  endfunction

endpackage

// File: rtl/alu4_seq_if.sv
// Command, ALU-drive and response signals of the sequencer, bundled with a
// master (sequencer) and slave (environment: command source, ALU, consumer) view.
interface alu4_seq_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
);
  // Both cmd and rsp are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the offering side holds its payload until then.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [IDXW-1:0]  cmd_rd;
  logic [IDXW-1:0]  cmd_rs1;
  logic [IDXW-1:0]  cmd_rs2;
  logic [WIDTH-1:0] cmd_imm;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_c;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_overflow;
  logic             alu_carry;
  logic             alu_size;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  alu_result, alu_zero, alu_overflow, alu_carry, alu_size,
    input  rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_c, alu_cin,
    output rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output alu_result, alu_zero, alu_overflow, alu_carry, alu_size,
    output rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_c, alu_cin,
    input  rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu4_regfile.sv
// Operand register file: two asynchronous read ports, one synchronous write
// port, whole array cleared by the asynchronous reset.
module alu4_regfile #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int IW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [IW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IW-1:0]    i_raddr1,
  input  logic [IW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2
);
  logic [WIDTH-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];
endmodule

// File: rtl/alu4_seq.sv
// Command sequencer in front of the 4-bit ALU: accepts register commands, holds
// the ALU operands for ALU_LAT cycles, writes the result back and responds.
module alu4_seq
  import alu4_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NREG    = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  alu4_seq_if.master bus,
  output state_t     o_state
);
  localparam int IW = $clog2(NREG);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_fn;
  logic [IW-1:0]    r_rd;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_valid;

  logic             w_accept;
  logic             w_is_li;
  logic             w_last;
  logic             w_is_cmp;
  logic             w_we;
  logic [IW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rs1_data;
  logic [WIDTH-1:0] w_rs2_data;

  // Gated by rst_n so ready is low during reset yet high in the very first IDLE cycle.
  assign bus.cmd_ready = rst_n && (r_state == ST_IDLE);
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  assign w_is_li       = bus.cmd_op[OP_LI_BIT];
  assign w_last        = (r_state == ST_EXEC) && (r_cnt == CW'(ALU_LAT - 1));
  assign w_is_cmp      = (r_fn == FN_LT) || (r_fn == FN_EQ);
  assign w_we          = (w_accept && w_is_li) || (w_last && !w_is_cmp);
  assign w_waddr       = (r_state == ST_IDLE) ? bus.cmd_rd  : r_rd;
  assign w_wdata       = (r_state == ST_IDLE) ? bus.cmd_imm : bus.alu_result;

  alu4_regfile #(.WIDTH(WIDTH), .NREG(NREG), .IW(IW)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr1 (bus.cmd_rs1),
    .i_raddr2 (bus.cmd_rs2),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_fn        <= '0;
      r_rd        <= '0;
      r_cin       <= 1'b0;
      r_cnt       <= '0;
      r_flags     <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_is_li) begin
              r_rsp_data  <= bus.cmd_imm;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_a     <= w_rs1_data;
              r_b     <= w_rs2_data;
              r_fn    <= bus.cmd_op[2:0];
              r_rd    <= bus.cmd_rd;
              r_cin   <= fn_uses_cin(bus.cmd_op[2:0]);
              r_cnt   <= '0;
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (w_last) begin
            r_rsp_data  <= bus.alu_result;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
            case (r_fn)
              FN_ADD, FN_SUB: begin
                r_flags[FLG_Z] <= bus.alu_zero;
                r_flags[FLG_O] <= bus.alu_overflow;
                r_flags[FLG_C] <= bus.alu_carry;
              end
              FN_LT, FN_EQ: begin
                r_flags[FLG_S] <= bus.alu_size;
                r_flags[FLG_Z] <= bus.alu_zero;
              end
              default: begin
                r_flags[FLG_Z] <= ~|bus.alu_result;
                r_flags[FLG_O] <= 1'b0;
                r_flags[FLG_C] <= 1'b0;
              end
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_c     = r_fn;
  assign bus.alu_cin   = r_cin;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_flags = r_flags;
  assign o_state       = r_state;
endmodule

// File: tb/tb_alu4_seq.sv
// Bench for alu4_seq: a behavioural ALU stand-in, a register/flag model that
// predicts every response, and directed command vectors with literal checks.
module tb_alu4_seq;
  import alu4_pkg::*;

  localparam int W    = 4;
  localparam int NREG = 4;
  localparam int LAT  = 2;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu4_seq_if #(.WIDTH(W), .IDXW(2)) bus ();

  alu4_seq #(.WIDTH(W), .NREG(NREG), .ALU_LAT(LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ALU behaviour: returns {size, carry, overflow, zero, result}.
  // size is the adder carry for compares, i.e. a >= b unsigned.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] c, input logic cin);
    logic [4:0] sum;
    logic [3:0] r;
    logic       o, cy, sz;
    sum = 5'd0; o = 1'b0; cy = 1'b0; sz = 1'b0;
    case (c)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        r = sum[3:0]; cy = sum[4];
        o = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1, 3'd6, 3'd7: begin
        sum = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        r = sum[3:0]; cy = sum[4];
        o = (a[3] != b[3]) && (r[3] != a[3]);
        if (c != 3'd1) sz = cy;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = ~a;
    endcase
    return {sz, cy, o, (r == 4'd0), r};
  endfunction

  logic [7:0] alu_out;
  always_comb begin
    alu_out          = alu_fn(bus.alu_a, bus.alu_b, bus.alu_c, bus.alu_cin);
    bus.alu_result   = alu_out[3:0];
    bus.alu_zero     = alu_out[4];
    bus.alu_overflow = alu_out[5];
    bus.alu_carry    = alu_out[6];
    bus.alu_size     = alu_out[7];
  end

  // Architectural model: registers, {S,C,O,Z} flags and expected-response queues.
  logic [W-1:0] m_reg [NREG];
  logic [3:0]   m_flags;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_flags_q[$];
  int           exp_lat_q[$];
  int           acc_cyc_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_flags = 4'd0;
  endtask

  task automatic model_accept(input logic [3:0] op, input logic [1:0] rd,
                              input logic [1:0] rs1, input logic [1:0] rs2,
                              input logic [3:0] imm);
    logic [7:0] res;
    logic [2:0] fn;
    fn = op[2:0];
    if (op[3]) begin
      m_reg[rd] = imm;
      exp_q.push_back(imm);
      exp_lat_q.push_back(1);
    end else begin
      res = alu_fn(m_reg[rs1], m_reg[rs2], fn, (fn == 3'd1) || (fn == 3'd6) || (fn == 3'd7));
      if (fn <= 3'd1) begin
        m_flags[0] = res[4]; m_flags[1] = res[5]; m_flags[2] = res[6];
      end else if (fn >= 3'd6) begin
        m_flags[3] = res[7]; m_flags[0] = res[4];
      end else begin
        m_flags[0] = (res[3:0] == 4'd0); m_flags[1] = 1'b0; m_flags[2] = 1'b0;
      end
      if (fn < 3'd6) m_reg[rd] = res[3:0];
      exp_q.push_back(res[3:0]);
      exp_lat_q.push_back(LAT + 1);
    end
    exp_flags_q.push_back(m_flags);
    acc_cyc_q.push_back(cyc);
  endtask

  // Compare process: first response cycle against the model, later cycles for stability.
  bit           in_rsp = 0;
  logic [W-1:0] hold_data;
  logic [3:0]   hold_flags;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 0;
    end else if (bus.rsp_valid) begin
      if (!in_rsp) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          hold_data  = exp_q.pop_front();
          hold_flags = exp_flags_q.pop_front();
          check("rsp_data", bus.rsp_data, hold_data);
          check("rsp_flags", bus.rsp_flags, hold_flags);
          check("rsp_latency", cyc - acc_cyc_q.pop_front(), exp_lat_q.pop_front());
        end
        in_rsp = 1;
      end else begin
        check("rsp_data_stable", bus.rsp_data, hold_data);
        check("rsp_flags_stable", bus.rsp_flags, hold_flags);
      end
      check("cmd_ready_in_resp", bus.cmd_ready, 1'b0);
      if (bus.rsp_ready) in_rsp = 0;
    end
  end

  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [3:0] imm, input bit abandon);
    bit ok;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd;
    bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1;
    end
    if (!ok) check("cmd_accept_timeout", 32'd1, 32'd0);
    else if (!abandon) model_accept(op, rd, rs1, rs2, imm);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [W-1:0] data, output logic [3:0] flags);
    bit ok;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) ok = 1;
    end
    if (!ok) check("rsp_timeout", 32'd1, 32'd0);
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1;
    data = bus.rsp_data;
    flags = bus.rsp_flags;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, bus.rsp_data, 4'd0);
    check({tag, "_rsp_flags"}, bus.rsp_flags, 4'd0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 8'd0);
    check({tag, "_alu_c_cin"}, {bus.alu_c, bus.alu_cin}, 4'd0);
  endtask

  localparam logic [3:0] LI = 4'b1000;

  initial begin : timeout_guard
    #400000;
    check("global_timeout", 32'd1, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : main
    logic [W-1:0] d;
    logic [3:0]   f;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0;
    bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;
    bus.rsp_ready = 1'b0;
    model_reset();

    // 1: reset
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // 2: LI r1=5, LI r2=3, ADD r0=r1+r2
    send(LI, 2'd1, 2'd0, 2'd0, 4'd5, 0); get_rsp(0, d, f);
    check("li_r1_data", d, 4'd5);
    send(LI, 2'd2, 2'd0, 2'd0, 4'd3, 0); get_rsp(0, d, f);
    send({1'b0, FN_ADD}, 2'd0, 2'd1, 2'd2, 4'd0, 0); get_rsp(0, d, f);
    check("add_5_3_data", d, 4'd8);
    check("add_5_3_C_Z", {f[2], f[0]}, 2'b00);

    // 3: 7+1 overflows signed; r3-r3 is zero
    send(LI, 2'd1, 2'd0, 2'd0, 4'd7, 0); get_rsp(0, d, f);
    send(LI, 2'd2, 2'd0, 2'd0, 4'd1, 0); get_rsp(0, d, f);
    send({1'b0, FN_ADD}, 2'd3, 2'd1, 2'd2, 4'd0, 0); get_rsp(0, d, f);
    check("add_7_1_data", d, 4'b1000);
    check("add_7_1_O_C", {f[1], f[2]}, 2'b10);
    send({1'b0, FN_SUB}, 2'd3, 2'd3, 2'd3, 4'd0, 0); get_rsp(0, d, f);
    check("sub_self_data", d, 4'd0);
    check("sub_self_Z", f[0], 1'b1);

    // 4: compares set S and leave rd alone
    send(LI, 2'd1, 2'd0, 2'd0, 4'd4, 0); get_rsp(0, d, f);
    send(LI, 2'd2, 2'd0, 2'd0, 4'd6, 0); get_rsp(0, d, f);
    send({1'b0, FN_LT}, 2'd0, 2'd1, 2'd2, 4'd0, 0); get_rsp(0, d, f);
    check("lt_4_6_S", f[3], 1'b0);
    send({1'b0, FN_EQ}, 2'd2, 2'd1, 2'd1, 4'd0, 0); get_rsp(0, d, f);
    check("eq_4_4_S", f[3], 1'b1);
    send({1'b0, FN_OR}, 2'd3, 2'd0, 2'd0, 4'd0, 0); get_rsp(0, d, f);
    check("r0_kept_after_lt", d, 4'd8);

    // 5: backpressure, stability checked by the compare process
    send({1'b0, FN_ADD}, 2'd1, 2'd1, 2'd2, 4'd0, 0); get_rsp(5, d, f);
    check("bp_add_4_6_data", d, 4'hA);

    // remaining function codes and rd==rs1==rs2
    send({1'b0, FN_AND}, 2'd0, 2'd1, 2'd2, 4'd0, 0); get_rsp(0, d, f);
    send({1'b0, FN_XOR}, 2'd3, 2'd1, 2'd2, 4'd0, 0); get_rsp(1, d, f);
    send({1'b0, FN_NOT}, 2'd2, 2'd1, 2'd0, 4'd0, 0); get_rsp(0, d, f);
    check("not_a_data", d, 4'h5);
    send({1'b0, FN_SUB}, 2'd0, 2'd2, 2'd1, 4'd0, 0); get_rsp(2, d, f);
    check("sub_5_10_data", d, 4'hB);
    send({1'b0, FN_ADD}, 2'd1, 2'd1, 2'd1, 4'd0, 0); get_rsp(0, d, f);
    send({1'b0, FN_EQ}, 2'd3, 2'd0, 2'd2, 4'd0, 0); get_rsp(0, d, f);

    // 6: reset during EXEC abandons the command
    send({1'b0, FN_ADD}, 2'd0, 2'd1, 2'd2, 4'd0, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("midexec_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_rsp_after_reset", bus.rsp_valid, 1'b0);
    end
    send({1'b0, FN_ADD}, 2'd1, 2'd0, 2'd0, 4'd0, 0); get_rsp(0, d, f);
    check("r0_cleared_add", d, 4'd0);
    check("r0_cleared_flags", f, 4'b0001);

    repeat (3) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
